fwft_unpacker: RTL

- Downstream consumer of the first-word-fall-through FIFO.
- Takes wide words from the FIFO head and emits them as a counted burst of narrow beats on a valid/ready stream, LSB slice first.
- A command (start + beat count) defines each burst. If the count is not a multiple of RATIO, the unused slices of the final word are discarded.
- Sits between the FWFT buffer and the PE-array input lanes.

---
 rtl/fwft_unpacker_pkg.sv | 20 ++
 rtl/unpack_slice_mux.sv | 26 ++
 rtl/fwft_unpacker.sv | 98 +++++++++
 3 files changed

// File: rtl/fwft_unpacker_pkg.sv
// Shared types and helpers for the FWFT word-to-beat unpacker.
// State encoding is fixed so it can be probed by number in waveforms.
package fwft_unpacker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/unpack_slice_mux.sv
// Selects one OUT_WIDTH slice of a wide word by index; pure combinational.
// Out-of-range indices return zero, so RATIO need not be a power of two.
module unpack_slice_mux
  import fwft_unpacker_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter int SEL_WIDTH = (clog2(IN_WIDTH / OUT_WIDTH) > 0) ? clog2(IN_WIDTH / OUT_WIDTH) : 1
) (
  input  logic [IN_WIDTH-1:0]  word,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [OUT_WIDTH-1:0] slice
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;

  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    slice = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (sel == SEL_WIDTH'(i)) slice = word[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

endmodule

// File: rtl/fwft_unpacker.sv
// Pulls wide words from a first-word-fall-through FIFO head and emits a
// counted burst of narrow beats, LSB slice first, on a valid/ready stream.
module fwft_unpacker
  import fwft_unpacker_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_num,
  output logic                 busy,
  output logic                 done,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_vld,
  output logic                 out_last,
  input  logic                 out_rdy
);

  localparam int RATIO   = IN_WIDTH / OUT_WIDTH;
  localparam int SLICE_W = (clog2(RATIO) > 0) ? clog2(RATIO) : 1;
  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(RATIO - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] remain;
  logic [SLICE_W-1:0]   slice;
  logic                 drain_pend;
  logic [OUT_WIDTH-1:0] head_slice;
  logic                 load, last_acc, drain_pop, last_load;

  unpack_slice_mux #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SEL_WIDTH(SLICE_W)
  ) u_mux (
    .word (fifo_dout),
    .sel  (slice),
    .slice(head_slice)
  );

  always_comb begin
    load      = (state == RUN) && (!out_vld || out_rdy) && !fifo_empty && (remain != '0);
    last_load = load && (remain == CNT_WIDTH'(1));
    last_acc  = out_vld && out_rdy && out_last;
    drain_pop = (state == DRAIN) && drain_pend && !fifo_empty;
    // A synchronous clear abandons the burst, so the head word must survive it.
    fifo_pop  = !Reset && ((load && slice == LAST_SLICE) || drain_pop);
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_num == '0) ? DONE : RUN;
      RUN:     if (last_load && slice != LAST_SLICE) state_nxt = DRAIN;
               else if (last_acc) state_nxt = DONE;
      DRAIN:   if ((!drain_pend || drain_pop) && (!out_vld || last_acc)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;  remain <= '0;  slice <= '0;  drain_pend <= 1'b0;
      out_data <= '0; out_vld <= 1'b0; out_last <= 1'b0;
    end else if (Reset) begin
      state <= IDLE;  remain <= '0;  slice <= '0;  drain_pend <= 1'b0;
      out_data <= '0; out_vld <= 1'b0; out_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start && cfg_num != '0) begin
        remain <= cfg_num;
        slice  <= '0;
      end
      if (load) begin
        out_data <= head_slice;
        out_vld  <= 1'b1;
        out_last <= (remain == CNT_WIDTH'(1));
        remain   <= remain - CNT_WIDTH'(1);
        slice    <= (slice == LAST_SLICE) ? '0 : slice + SLICE_W'(1);
      end else if (out_rdy) begin
        out_vld  <= 1'b0;
        out_last <= 1'b0;
      end
      // A burst ending mid-word leaves the partial word at the head to discard.
      if (last_load && slice != LAST_SLICE) drain_pend <= 1'b1;
      else if (drain_pop)                   drain_pend <= 1'b0;
    end
  end

endmodule
